tmr_fault_injector: RTL and testbench

// - Stimulus/check end of the TMR voter interface. Takes a word stream and fans each word out into three replica lanes (A/B/C).
// - Inverts lanes on request via the per-lane error_ctrl lines.
// - Holds a cycle-exact model of the voter's sticky lane-fault state and checks the voter's data_out/TMR_error every driven cycle.
// - Used in silicon self-test and in system benches in front of the voter.

---
 rtl/tmr_fault_injector_pkg.sv | 17 +
 rtl/tmr_voter_model.sv | 41 ++++
 rtl/tmr_fault_injector.sv | 111 +++++++++++
 tb/tb_tmr_fault_injector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_fault_injector_pkg.sv
// rtl/tmr_fault_injector_pkg.sv - shared widths, FSM states and lane indices for the TMR fault injector
package tmr_fault_injector_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int CNT_W_DEF    = 16;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tmr_voter_model.sv
// rtl/tmr_voter_model.sv - expected voter output and next sticky lane-fault state
module tmr_voter_model
  import tmr_fault_injector_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic [DATA_LEN-1:0] e_a,
  input  logic [DATA_LEN-1:0] e_b,
  input  logic [DATA_LEN-1:0] e_c,
  input  logic [2:0]          fault_vec,
  output logic [DATA_LEN-1:0] exp_data,
  output logic                exp_error,
  output logic [2:0]          fault_next
);

  logic ab_diff, ac_diff, bc_diff;

  always_comb begin
    ab_diff   = (e_a != e_b);
    ac_diff   = (e_a != e_c);
    bc_diff   = (e_b != e_c);
    exp_data  = (e_a & e_b) | (e_a & e_c) | (e_b & e_c);
    exp_error = 1'b0;
    // Once a lane is flagged the voter runs simplex/duplex on the remaining lanes, A taking priority.
    if (fault_vec[LANE_A]) begin
      exp_data  = e_b;
      exp_error = bc_diff;
    end else if (fault_vec[LANE_B]) begin
      exp_data  = e_c;
      exp_error = ac_diff;
    end else if (fault_vec[LANE_C]) begin
      exp_data  = e_a;
      exp_error = ab_diff;
    end
    fault_next         = fault_vec;
    fault_next[LANE_A] = fault_vec[LANE_A] | (ab_diff & ac_diff);
    fault_next[LANE_B] = fault_vec[LANE_B] | (ab_diff & bc_diff);
    fault_next[LANE_C] = fault_vec[LANE_C] | (bc_diff & ac_diff);
  end

endmodule

// File: rtl/tmr_fault_injector.sv
// rtl/tmr_fault_injector.sv - replicates a word stream into three lanes with inversion and checks the voter
module tmr_fault_injector
  import tmr_fault_injector_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    run_len,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic [2:0]          in_inj,
  output logic                in_ready,
  output logic [DATA_LEN-1:0] dataA_out,
  output logic [DATA_LEN-1:0] dataB_out,
  output logic [DATA_LEN-1:0] dataC_out,
  output logic                A_error_ctrl,
  output logic                B_error_ctrl,
  output logic                C_error_ctrl,
  input  logic [DATA_LEN-1:0] voter_data,
  input  logic                voter_error,
  output logic                chk_valid,
  output logic                chk_pass,
  output logic [2:0]          fault_vec,
  output logic [CNT_W-1:0]    word_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    run_len_q, acc_cnt;
  logic                drv_vld, accept;
  logic [DATA_LEN-1:0] e_a, e_b, e_c, exp_data;
  logic                exp_error;
  logic [2:0]          fault_next;

  assign e_a       = A_error_ctrl ? ~dataA_out : dataA_out;
  assign e_b       = B_error_ctrl ? ~dataB_out : dataB_out;
  assign e_c       = C_error_ctrl ? ~dataC_out : dataC_out;
  assign in_ready  = (state == RUN) && (acc_cnt < run_len_q);
  assign accept    = in_valid && in_ready;
  assign chk_valid = drv_vld;
  assign chk_pass  = drv_vld && (voter_data == exp_data) && (voter_error == exp_error);
  assign done      = (state == DONE);

  tmr_voter_model #(.DATA_LEN(DATA_LEN)) u_model (
    .e_a        (e_a),
    .e_b        (e_b),
    .e_c        (e_c),
    .fault_vec  (fault_vec),
    .exp_data   (exp_data),
    .exp_error  (exp_error),
    .fault_next (fault_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (run_len == '0) ? DONE : RUN;
      RUN:  if (drv_vld && ((word_cnt + ONE) == run_len_q)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      run_len_q    <= '0;
      acc_cnt      <= '0;
      drv_vld      <= 1'b0;
      dataA_out    <= '0;
      dataB_out    <= '0;
      dataC_out    <= '0;
      A_error_ctrl <= 1'b0;
      B_error_ctrl <= 1'b0;
      C_error_ctrl <= 1'b0;
      fault_vec    <= '0;
      word_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      state     <= state_nxt;
      // The shadow tracks the voter's sticky flags on every edge, held lanes included.
      fault_vec <= fault_next;
      drv_vld   <= accept;
      if (accept) begin
        dataA_out    <= in_data;
        dataB_out    <= in_data;
        dataC_out    <= in_data;
        A_error_ctrl <= in_inj[LANE_A];
        B_error_ctrl <= in_inj[LANE_B];
        C_error_ctrl <= in_inj[LANE_C];
        acc_cnt      <= acc_cnt + ONE;
      end
      if (state == IDLE && start) begin
        run_len_q <= run_len;
        acc_cnt   <= '0;
        word_cnt  <= '0;
        err_cnt   <= '0;
      end else if (drv_vld) begin
        word_cnt <= word_cnt + ONE;
        if (!chk_pass && (err_cnt != '1)) err_cnt <= err_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_tmr_fault_injector.sv
// tb/tb_tmr_fault_injector.sv - directed table-driven bench for tmr_fault_injector
module tb_tmr_fault_injector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] run_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_inj;
  logic        in_ready;
  logic [7:0]  dataA_out, dataB_out, dataC_out;
  logic        A_error_ctrl, B_error_ctrl, C_error_ctrl;
  logic [7:0]  voter_data;
  logic        voter_error;
  logic        chk_valid, chk_pass;
  logic [2:0]  fault_vec;
  logic [15:0] word_cnt, err_cnt;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] inj;
    logic [7:0] v_data;
    logic       v_err;
    logic       exp_pass;
    logic [2:0] exp_fault;
  } vec_t;

  vec_t vec[14];

  always #5 clk = ~clk;

  tmr_fault_injector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .run_len      (run_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_inj       (in_inj),
    .in_ready     (in_ready),
    .dataA_out    (dataA_out),
    .dataB_out    (dataB_out),
    .dataC_out    (dataC_out),
    .A_error_ctrl (A_error_ctrl),
    .B_error_ctrl (B_error_ctrl),
    .C_error_ctrl (C_error_ctrl),
    .voter_data   (voter_data),
    .voter_error  (voter_error),
    .chk_valid    (chk_valid),
    .chk_pass     (chk_pass),
    .fault_vec    (fault_vec),
    .word_cnt     (word_cnt),
    .err_cnt      (err_cnt),
    .done         (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_lanes"}, {dataA_out, dataB_out, dataC_out}, 64'h0);
    check({name, "_ctrl"}, {A_error_ctrl, B_error_ctrl, C_error_ctrl}, 64'h0);
    check({name, "_flags"}, {in_ready, chk_valid, chk_pass, done}, 64'h0);
    check({name, "_fault_vec"}, fault_vec, 64'h0);
    check({name, "_cnts"}, {word_cnt, err_cnt}, 64'h0);
  endtask

  task automatic pulse_start(input logic [15:0] len);
    @(negedge clk);
    start   = 1'b1;
    run_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_word(input int i);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vec[i].data;
    in_inj   = vec[i].inj;
    check($sformatf("ready_v%0d", i), in_ready, 64'h1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    voter_data  = vec[i].v_data;
    voter_error = vec[i].v_err;
    @(negedge clk);
    check($sformatf("chk_valid_v%0d", i), chk_valid, 64'h1);
    check($sformatf("chk_pass_v%0d", i), chk_pass, {63'h0, vec[i].exp_pass});
    check($sformatf("lanes_v%0d", i),
          {dataA_out, dataB_out, dataC_out, C_error_ctrl, B_error_ctrl, A_error_ctrl},
          {vec[i].data, vec[i].data, vec[i].data, vec[i].inj});
    @(posedge clk);
    #1 check($sformatf("fault_vec_v%0d", i), fault_vec, {61'h0, vec[i].exp_fault});
  endtask

  task automatic do_run(input int first, input int n, input int exp_err);
    pulse_start(16'(n));
    for (int i = first; i < first + n; i++) run_word(i);
    @(negedge clk);
    check($sformatf("done_run%0d", first), done, 64'h1);
    check($sformatf("word_cnt_run%0d", first), word_cnt, 64'(n));
    check($sformatf("err_cnt_run%0d", first), err_cnt, 64'(exp_err));
    @(negedge clk);
    check($sformatf("done_drop_run%0d", first), {done, in_ready}, 64'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec[0]  = '{8'h5A, 3'b000, 8'h5A, 1'b0, 1'b1, 3'b000};
    vec[1]  = '{8'h00, 3'b000, 8'h00, 1'b0, 1'b1, 3'b000};
    vec[2]  = '{8'hFF, 3'b000, 8'hFF, 1'b0, 1'b1, 3'b000};
    vec[3]  = '{8'h3C, 3'b000, 8'h3C, 1'b0, 1'b1, 3'b000};
    vec[4]  = '{8'h5A, 3'b001, 8'h5A, 1'b0, 1'b1, 3'b001};
    vec[5]  = '{8'h11, 3'b100, 8'h11, 1'b1, 1'b1, 3'b101};
    vec[6]  = '{8'h12, 3'b000, 8'h13, 1'b0, 1'b0, 3'b101};
    vec[7]  = '{8'h34, 3'b000, 8'h34, 1'b0, 1'b1, 3'b101};
    vec[8]  = '{8'h56, 3'b000, 8'h57, 1'b0, 1'b0, 3'b101};
    vec[9]  = '{8'h78, 3'b000, 8'h78, 1'b0, 1'b1, 3'b101};
    vec[10] = '{8'h9A, 3'b000, 8'h9B, 1'b0, 1'b0, 3'b101};
    vec[11] = '{8'hF0, 3'b011, 8'h0F, 1'b0, 1'b1, 3'b100};
    vec[12] = '{8'h0F, 3'b000, 8'h0F, 1'b0, 1'b1, 3'b100};
    vec[13] = '{8'hAA, 3'b010, 8'hAA, 1'b0, 1'b1, 3'b010};

    reset_n     = 1'b0;
    start       = 1'b0;
    run_len     = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_inj      = '0;
    voter_data  = '0;
    voter_error = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    do_run(0, 4, 0);
    do_run(4, 2, 0);
    do_run(6, 5, 3);

    apply_reset();
    do_run(11, 2, 0);

    // Zero-length run goes straight to DONE and never offers ready.
    pulse_start(16'd0);
    check("t5_ready", in_ready, 64'h0);
    @(negedge clk);
    check("t5_done", {done, in_ready}, 64'h2);
    @(negedge clk);
    check("t5_done_drop", done, 64'h0);

    // Offered word with ready low is not consumed.
    in_valid = 1'b1;
    in_data  = 8'h66;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("idle_no_accept", {chk_valid, dataA_out}, {1'b0, 8'h0F});

    apply_reset();
    pulse_start(16'd3);
    run_word(13);
    pulse_start(16'd0);
    @(negedge clk);
    check("start_ignored_ready", {in_ready, done}, 64'h2);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_inj   = 3'b000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t6_inflight", {chk_valid, fault_vec}, {1'b1, 3'b010});
    reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
